// File: rtl/rr_priority_finder_pkg.sv
// rtl/rr_priority_finder_pkg.sv - shared helpers for the round-robin priority finder
//
// Purpose: modulo-wrap helper used for pointer rotation and un-rotation, where
// WIDTH need not be a power of two, so wrap cannot rely on bit truncation.
// Ports: none (package).
package rr_priority_finder_pkg;

    // Non-negative remainder of value modulo width, valid for negative inputs.
    function automatic int wrap_idx(input int value, input int width);
        int r;
        r = value % width;
        if (r < 0) begin
            r = r + width;
        end
        return r;
    endfunction

endpackage

// File: rtl/priority_finder.sv
// rtl/priority_finder.sv - single-grant fixed-priority finder
//
// Purpose: returns the index of the first set bit of req, searching from bit 0
// upward (FIRST_PRIORITY=1) or from bit WIDTH-1 downward (FIRST_PRIORITY=0).
// Ports:
//   req   in  WIDTH          request vector
//   index out $clog2(WIDTH)  index of the found bit, 0 when none
//   valid out 1              at least one bit of req is set
module priority_finder
    import rr_priority_finder_pkg::*;
#(
    parameter int FIRST_PRIORITY = 1,
    parameter int WIDTH          = 8
) (
    input  logic [WIDTH-1:0]         req,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     valid
);

    localparam int IW = $clog2(WIDTH);

    // The loop visits the winning end last so the final assignment wins.
    always_comb begin
        index = '0;
        if (FIRST_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    index = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    index = IW'(i);
                end
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/rr_priority_finder.sv
// rtl/rr_priority_finder.sv - round-robin multi-grant priority finder
//
// Purpose: scans req from a registered rotating pointer and returns up to
// GRANT_NUM set-bit indices per cycle; on accept the pointer moves past the
// last grant so every requester is served fairly.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req          request vector
//   accept       consumer takes this cycle's grants
//   grant_index  index of grant k (0 when grant k is absent)
//   grant_valid  grant k exists
//   grant_mask   OR of one-hot encodings of all valid grants
//   ptr          current scan start
module rr_priority_finder
    import rr_priority_finder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int GRANT_NUM      = 2,
    parameter int FIRST_PRIORITY = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [WIDTH-1:0]                           req,
    input  logic                                       accept,
    output logic [GRANT_NUM-1:0][$clog2(WIDTH)-1:0]    grant_index,
    output logic [GRANT_NUM-1:0]                       grant_valid,
    output logic [WIDTH-1:0]                           grant_mask,
    output logic [$clog2(WIDTH)-1:0]                   ptr
);

    localparam int            IW        = $clog2(WIDTH);
    localparam logic [IW-1:0] PTR_RESET = (FIRST_PRIORITY != 0) ? IW'(0) : IW'(WIDTH - 1);

    logic [IW-1:0]                 ptr_q;
    logic [IW-1:0]                 ptr_d;
    logic [WIDTH-1:0]              rot_req;
    logic [GRANT_NUM-1:0][WIDTH-1:0] avail;
    logic [GRANT_NUM-1:0][IW-1:0]  rot_idx;
    logic [GRANT_NUM-1:0]          stage_valid;
    logic [IW-1:0]                 last_idx;

    // Rotate req so ptr lands on bit 0 (upward) or bit WIDTH-1 (downward);
    // each stage then only needs a fixed-priority search.
    always_comb begin
        int src;
        rot_req = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (FIRST_PRIORITY != 0) begin
                src = wrap_idx(int'(ptr_q) + i, WIDTH);
            end else begin
                src = wrap_idx(int'(ptr_q) - (WIDTH - 1 - i), WIDTH);
            end
            rot_req[i] = req[IW'(src)];
        end
    end

    assign avail[0] = rot_req;

    // Stage k sees the rotated request with all earlier grants removed.
    for (genvar k = 0; k < GRANT_NUM; k++) begin : g_stage
        priority_finder #(
            .FIRST_PRIORITY (FIRST_PRIORITY),
            .WIDTH          (WIDTH)
        ) u_pf (
            .req   (avail[k]),
            .index (rot_idx[k]),
            .valid (stage_valid[k])
        );

        if (k + 1 < GRANT_NUM) begin : g_mask
            assign avail[k+1] = avail[k] &
                ~(stage_valid[k] ? (WIDTH'(1) << rot_idx[k]) : {WIDTH{1'b0}});
        end
    end

    // Un-rotate stage results back to req bit positions.
    always_comb begin
        grant_index = '0;
        grant_mask  = '0;
        last_idx    = '0;
        for (int k = 0; k < GRANT_NUM; k++) begin
            if (stage_valid[k]) begin
                if (FIRST_PRIORITY != 0) begin
                    grant_index[k] = IW'(wrap_idx(int'(ptr_q) + int'(rot_idx[k]), WIDTH));
                end else begin
                    grant_index[k] = IW'(wrap_idx(int'(ptr_q) - (WIDTH - 1 - int'(rot_idx[k])), WIDTH));
                end
                grant_mask = grant_mask | (WIDTH'(1) << grant_index[k]);
                last_idx   = grant_index[k];
            end
        end
        grant_valid = stage_valid;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && stage_valid[0]) begin
            if (FIRST_PRIORITY != 0) begin
                ptr_d = IW'(wrap_idx(int'(last_idx) + 1, WIDTH));
            end else begin
                ptr_d = IW'(wrap_idx(int'(last_idx) - 1, WIDTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_RESET;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: tb/tb_rr_priority_finder.sv
// tb/tb_rr_priority_finder.sv - directed self-checking bench for rr_priority_finder
module tb_rr_priority_finder;

    logic            clk;
    logic            rst;
    logic [7:0]      req_u, req_d;
    logic            acc_u, acc_d;
    logic [1:0][2:0] gi_u, gi_d;
    logic [1:0]      gv_u, gv_d;
    logic [7:0]      gm_u, gm_d;
    logic [2:0]      ptr_u, ptr_d;

    int n_checks;
    int n_errors;

    rr_priority_finder #(.WIDTH(8), .GRANT_NUM(2), .FIRST_PRIORITY(1)) u_up (
        .clk         (clk),
        .rst         (rst),
        .req         (req_u),
        .accept      (acc_u),
        .grant_index (gi_u),
        .grant_valid (gv_u),
        .grant_mask  (gm_u),
        .ptr         (ptr_u)
    );

    rr_priority_finder #(.WIDTH(8), .GRANT_NUM(2), .FIRST_PRIORITY(0)) u_dn (
        .clk         (clk),
        .rst         (rst),
        .req         (req_d),
        .accept      (acc_d),
        .grant_index (gi_d),
        .grant_valid (gv_d),
        .grant_mask  (gm_d),
        .ptr         (ptr_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept_up();
        acc_u = 1'b1;
        @(posedge clk);
        #1;
        acc_u = 1'b0;
    endtask

    task automatic accept_dn();
        acc_d = 1'b1;
        @(posedge clk);
        #1;
        acc_d = 1'b0;
    endtask

    task automatic check_up(input string tag, input logic [2:0] i0, input logic [2:0] i1,
                            input logic [1:0] v, input logic [7:0] m);
        check({tag, "_idx0"}, 32'(gi_u[0]), 32'(i0));
        check({tag, "_idx1"}, 32'(gi_u[1]), 32'(i1));
        check({tag, "_valid"}, 32'(gv_u), 32'(v));
        check({tag, "_mask"}, 32'(gm_u), 32'(m));
    endtask

    logic [2:0] fair_ptr [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        fair_ptr = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0};
        rst   = 1'b1;
        req_u = '0;
        req_d = '0;
        acc_u = 1'b0;
        acc_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ptr_up", 32'(ptr_u), 32'd0);
        check("rst_ptr_dn", 32'(ptr_d), 32'd7);
        check_up("rst", 3'd0, 3'd0, 2'b00, 8'h00);
        check("rst_valid_dn", 32'(gv_d), 32'd0);
        rst = 1'b0;

        // Upward scan and wrap
        req_u = 8'b1001_0110;
        #1;
        check_up("up0", 3'd1, 3'd2, 2'b11, 8'h06);
        accept_up();
        check("up_ptr3", 32'(ptr_u), 32'd3);
        check_up("up1", 3'd4, 3'd7, 2'b11, 8'h90);
        accept_up();
        check("up_ptr_wrap", 32'(ptr_u), 32'd0);
        check_up("up2", 3'd1, 3'd2, 2'b11, 8'h06);

        // Single grant from ptr=3
        accept_up();
        check("sg_ptr3", 32'(ptr_u), 32'd3);
        req_u = 8'h01;
        #1;
        check_up("sg", 3'd0, 3'd0, 2'b01, 8'h01);
        accept_up();
        check("sg_ptr1", 32'(ptr_u), 32'd1);

        // Idle accept holds ptr
        req_u = 8'h00;
        #1;
        check("idle_valid", 32'(gv_u), 32'd0);
        accept_up();
        check("idle_ptr", 32'(ptr_u), 32'd1);

        // Downward scan
        req_d = 8'b0100_0011;
        #1;
        check("dn0_idx0", 32'(gi_d[0]), 32'd6);
        check("dn0_idx1", 32'(gi_d[1]), 32'd1);
        check("dn0_mask", 32'(gm_d), 32'h42);
        accept_dn();
        check("dn_ptr0", 32'(ptr_d), 32'd0);
        check("dn1_idx0", 32'(gi_d[0]), 32'd0);
        check("dn1_idx1", 32'(gi_d[1]), 32'd6);
        accept_dn();
        check("dn_ptr5", 32'(ptr_d), 32'd5);

        // Reset beats accept at ptr=4
        req_u = 8'h08;
        accept_up();
        check("pre_ptr4", 32'(ptr_u), 32'd4);
        req_u = 8'hFF;
        acc_u = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc_u = 1'b0;
        check("rst_prec_ptr", 32'(ptr_u), 32'd0);
        check("rst_prec_ptr_dn", 32'(ptr_d), 32'd7);

        // Fairness with accept held
        acc_u = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("fair%0d_ptr", c), 32'(ptr_u), 32'(fair_ptr[c]));
            check($sformatf("fair%0d_idx0", c), 32'(gi_u[0]), 32'((2 * c) % 8));
            check($sformatf("fair%0d_idx1", c), 32'(gi_u[1]), 32'((2 * c + 1) % 8));
            @(posedge clk);
            #1;
        end
        acc_u = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
